// File: rtl/alu_pkg.sv
// alu_pkg
// Shared definitions for the ALU unit-select path. Producers of the select
// code and consumers of the decoded select lines both import this package
// so that they agree on the encoding.
//   SEL_W      width of the unit-select code
//   DEC_W      number of one-hot select lines
//   alu_sel_e  unit-select encodings (ARITH, LOGIC, SHIFT, CMP)
package alu_pkg;

    localparam int SEL_W = 2;
    localparam int DEC_W = 4;

    typedef enum logic [SEL_W-1:0] {
        SEL_ARITH = 2'd0,
        SEL_LOGIC = 2'd1,
        SEL_SHIFT = 2'd2,
        SEL_CMP   = 2'd3
    } alu_sel_e;

endpackage

// File: rtl/onehot_dec_core.sv
// onehot_dec_core
// Purely combinational decode of an SEL_W-bit select code into DEC_W one-hot
// lines (bit n high for code n).
// Ports:
//   i_sel  [SEL_W-1:0]  select code
//   o_dec  [DEC_W-1:0]  one-hot decode; all-zero for an unknown code
module onehot_dec_core
    import alu_pkg::*;
(
    input  logic [SEL_W-1:0] i_sel,
    output logic [DEC_W-1:0] o_dec
);

    always_comb begin
        o_dec = '0;
        // An explicit case (rather than a shift) makes an X/Z select fall
        // through to the all-zero default instead of producing X/multi-hot.
        case (alu_sel_e'(i_sel))
            SEL_ARITH: o_dec = 4'b0001;
            SEL_LOGIC: o_dec = 4'b0010;
            SEL_SHIFT: o_dec = 4'b0100;
            SEL_CMP:   o_dec = 4'b1000;
            default:   o_dec = '0;
        endcase
    end

endmodule

// File: rtl/decoder_2_to_4.sv
// decoder_2_to_4
// Registered 2-to-4 one-hot decoder with enable, used as the ALU
// operation/unit-select stage. One cycle of latency, full throughput, outputs
// driven directly from flops.
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset; clears all outputs immediately
//   en     decode enable, sampled at the rising edge
//   in     2-bit select code, sampled at the rising edge
//   out0..out3  registered one-hot select lines (all zero when not enabled)
//   valid  registered enable; high when out0..out3 hold a fresh decode
module decoder_2_to_4
    import alu_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [SEL_W-1:0] in,
    output logic             out0,
    output logic             out1,
    output logic             out2,
    output logic             out3,
    output logic             valid
);

    logic [DEC_W-1:0] w_dec;
    logic [DEC_W-1:0] w_dec_gated;
    logic [DEC_W-1:0] r_dec;
    logic             r_valid;

    onehot_dec_core u_core (
        .i_sel (in),
        .o_dec (w_dec)
    );

    // Disabled cycles clear the lines; the previous code is never held.
    assign w_dec_gated = en ? w_dec : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dec   <= '0;
            r_valid <= 1'b0;
        end else begin
            r_dec   <= w_dec_gated;
            // Equal to en for every legal code; an unknown code decodes to
            // zero and so also drops valid, keeping the one-hot/zero pairing.
            r_valid <= en & (|w_dec);
        end
    end

    assign out0  = r_dec[0];
    assign out1  = r_dec[1];
    assign out2  = r_dec[2];
    assign out3  = r_dec[3];
    assign valid = r_valid;

`ifndef SYNTHESIS
    // Simulation-only checks: X/Z select while enabled, and the registered
    // outputs being one-hot when valid, all-zero otherwise.
    always @(posedge clk) begin
        if (rst_n && en) begin
            assert (!$isunknown(in))
                else $error("decoder_2_to_4: select input has X/Z while en=1 (in=%b)", in);
        end
        if (rst_n) begin
            assert (r_valid ? $onehot(r_dec) : (r_dec == '0))
                else $error("decoder_2_to_4: outputs not one-hot/zero (dec=%b valid=%b)",
                            r_dec, r_valid);
        end
    end
`endif

endmodule

// File: tb/tb_decoder_2_to_4.sv
module tb_decoder_2_to_4;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [1:0] in;
    logic       out0, out1, out2, out3, valid;

    int n_checks;
    int n_fail;

    decoder_2_to_4 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .in    (in),
        .out0  (out0),
        .out1  (out1),
        .out2  (out2),
        .out3  (out3),
        .valid (valid)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic       en;
        logic [1:0] in;
        logic [3:0] exp_out;
        logic       exp_valid;
    } vec_t;

    // Compare {valid, out3..out0} against the expected value.
    task automatic check(input string name, input logic [3:0] exp_out, input logic exp_valid);
        logic [4:0] act;
        logic [4:0] req;
        act = {valid, out3, out2, out1, out0};
        req = {exp_valid, exp_out};
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got valid=%b out=%b, expected valid=%b out=%b",
                     name, act[4], act[3:0], req[4], req[3:0]);
        end
    endtask

    // Apply inputs, clock once, sample 1 time unit after the edge.
    task automatic step(input logic e, input logic [1:0] s);
        en = e;
        in = s;
        @(posedge clk);
        #1;
    endtask

    vec_t vecs[10];

    initial begin
        logic [3:0] m_out;
        logic       m_valid;
        logic [3:0] dec;

        n_checks = 0;
        n_fail   = 0;

        // sweep
        vecs[0] = '{1'b1, 2'b00, 4'b0001, 1'b1};
        vecs[1] = '{1'b1, 2'b01, 4'b0010, 1'b1};
        vecs[2] = '{1'b1, 2'b10, 4'b0100, 1'b1};
        vecs[3] = '{1'b1, 2'b11, 4'b1000, 1'b1};
        // enable gating
        vecs[4] = '{1'b1, 2'b01, 4'b0010, 1'b1};
        vecs[5] = '{1'b0, 2'b01, 4'b0000, 1'b0};
        vecs[6] = '{1'b1, 2'b01, 4'b0010, 1'b1};
        // repeated code, then disabled with a different code
        vecs[7] = '{1'b1, 2'b01, 4'b0010, 1'b1};
        vecs[8] = '{1'b0, 2'b11, 4'b0000, 1'b0};
        vecs[9] = '{1'b1, 2'b10, 4'b0100, 1'b1};

        // Reset held with en=1, in=11: outputs stay clear across edges.
        rst_n = 1'b0;
        en    = 1'b1;
        in    = 2'b11;
        #2;
        check("reset_initial", 4'b0000, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        check("reset_held", 4'b0000, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("reset_release_first", 4'b1000, 1'b1);

        // Table-driven vectors.
        for (int i = 0; i < 10; i++) begin
            step(vecs[i].en, vecs[i].in);
            check($sformatf("vec%0d", i), vecs[i].exp_out, vecs[i].exp_valid);
        end

        // Asynchronous reset mid-stream, between edges.
        step(1'b1, 2'b10);
        check("async_pre", 4'b0100, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_immediate", 4'b0000, 1'b0);
        rst_n = 1'b1;
        en    = 1'b0;
        @(posedge clk);
        #1;
        check("async_after_edge_en0", 4'b0000, 1'b0);

        // Latency: change code 00 -> 11 one unit before the edge.
        step(1'b1, 2'b00);
        check("lat_base", 4'b0001, 1'b1);
        @(negedge clk);
        #4;
        in = 2'b11;
        #0;
        check("lat_before_edge", 4'b0001, 1'b1);
        @(posedge clk);
        #1;
        check("lat_after_edge", 4'b1000, 1'b1);

        // Random run against the shift model and one-hot/zero invariant.
        for (int c = 0; c < 1000; c++) begin
            logic       e;
            logic [1:0] s;
            e = 1'($urandom_range(0, 3) != 0);
            s = 2'($urandom_range(0, 3));
            m_valid = e;
            m_out   = e ? (4'b0001 << s) : 4'b0000;
            step(e, s);
            check("random", m_out, m_valid);
            dec = {out3, out2, out1, out0};
            n_checks++;
            if (valid ? !$onehot(dec) : (dec != 4'b0000)) begin
                n_fail++;
                $display("FAIL invariant: got valid=%b out=%b, expected one-hot when valid else zero",
                         valid, dec);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
